// File: rtl/servant_loader_pkg.sv
// rtl/servant_loader_pkg.sv - shared state encodings and byte-lane helpers for the servant loader
package servant_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int         LANE_W   = 8;
    localparam logic [3:0] SEL_NONE = 4'h0;
    localparam logic [3:0] SEL_ALL  = 4'hf;

    // Expand a 4-bit byte select into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/servant_loader_pack.sv
// rtl/servant_loader_pack.sv - packs a byte stream little-endian into one 32-bit word with lane selects
module servant_loader_pack
    import servant_loader_pkg::*;
(
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [3:0]  sel,
    output logic        word_full
);

    logic [1:0] cnt;

    // Three lanes already filled: the next accepted byte completes the word
    assign word_full = (cnt == 2'd3);

    // Byte counter picks the lane; unused lanes stay zero so partial words read cleanly
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            cnt  <= 2'd0;
            word <= '0;
            sel  <= SEL_NONE;
        end else if (clr) begin
            cnt  <= 2'd0;
            word <= '0;
            sel  <= SEL_NONE;
        end else if (load) begin
            word[{cnt, 3'b000} +: LANE_W] <= data;
            sel[cnt]                      <= 1'b1;
            cnt                           <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/servant_wb_loader.sv
// rtl/servant_wb_loader.sv - Wishbone boot loader for servant RAM; readback check under SERVANT_LOADER_VERIFY_EN
module servant_wb_loader
    import servant_loader_pkg::*;
#(
    parameter int depth     = 256,
    parameter int aw        = $clog2(depth),
    parameter bit AUTOSTART = 1'b1
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic          i_start,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_vld,
    input  logic          i_byte_last,
    output logic          o_byte_rdy,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_cpu_rst,
    output logic          o_done,
    output logic          o_err
);

`ifdef SERVANT_LOADER_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    localparam int              LAST_WORD   = depth / 4 - 1;
    localparam logic [aw-3:0]   LAST_ADR    = LAST_WORD[aw-3:0];
    localparam state_t          RESET_STATE = AUTOSTART ? ST_FILL : ST_IDLE;

    state_t        state, state_nxt;
    logic          cyc_nxt, we_nxt;
    logic [aw-3:0] adr_nxt;
    logic [31:0]   dat_nxt;
    logic [3:0]    sel_nxt;
    logic          err_q, err_nxt;
    logic          last_q, last_nxt;
    logic          pack_clr, word_done;
    logic          accept, rd_mismatch;
    logic [31:0]   pack_word;
    logic [3:0]    pack_sel;
    logic          word_full;

    assign accept = (state == ST_FILL) && o_byte_rdy && i_byte_vld;
    assign o_err  = err_q;

`ifdef SERVANT_LOADER_VERIFY_EN
    // Only the lanes actually written are meaningful in the readback
    assign rd_mismatch = |((i_wb_rdt ^ o_wb_dat) & lane_mask(pack_sel));
`else
    logic unused_rdt;
    assign unused_rdt  = ^i_wb_rdt;
    assign rd_mismatch = 1'b0;
`endif

    servant_loader_pack u_pack (
        .i_wb_clk  (i_wb_clk),
        .i_wb_rst  (i_wb_rst),
        .clr       (pack_clr),
        .load      (accept),
        .data      (i_byte),
        .word      (pack_word),
        .sel       (pack_sel),
        .word_full (word_full)
    );

    // Next-state and next-output decode; every bus output is registered below
    always_comb begin
        state_nxt = state;
        cyc_nxt   = o_wb_cyc;
        we_nxt    = o_wb_we;
        adr_nxt   = o_wb_adr;
        dat_nxt   = o_wb_dat;
        sel_nxt   = o_wb_sel;
        err_nxt   = err_q;
        last_nxt  = last_q;
        pack_clr  = 1'b0;
        word_done = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_nxt = ST_FILL;
                    adr_nxt   = '0;
                    err_nxt   = 1'b0;
                    last_nxt  = 1'b0;
                    pack_clr  = 1'b1;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    last_nxt = last_q | i_byte_last;
                    if (i_byte_last || word_full) begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!o_wb_cyc) begin
                    cyc_nxt = 1'b1;
                    we_nxt  = 1'b1;
                    dat_nxt = pack_word;
                    sel_nxt = pack_sel;
                end else if (i_wb_ack) begin
                    cyc_nxt = 1'b0;
                    we_nxt  = 1'b0;
                    if (VERIFY_EN) begin
                        state_nxt = ST_VERIFY;
                    end else begin
                        word_done = 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                if (!o_wb_cyc) begin
                    cyc_nxt = 1'b1;
                    we_nxt  = 1'b0;
                    sel_nxt = SEL_ALL;
                end else if (i_wb_ack) begin
                    cyc_nxt   = 1'b0;
                    word_done = 1'b1;
                    if (rd_mismatch) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A word has landed: stop at end of image or end of RAM, else move to the next word
        if (word_done) begin
            if (last_q || (o_wb_adr == LAST_ADR)) begin
                state_nxt = ST_DONE;
            end else begin
                state_nxt = ST_FILL;
                adr_nxt   = o_wb_adr + 1'b1;
                pack_clr  = 1'b1;
            end
        end
    end

    // State and output registers; reset drops the bus cycle immediately
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state      <= RESET_STATE;
            o_wb_cyc   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_wb_sel   <= SEL_NONE;
            o_byte_rdy <= 1'b0;
            o_cpu_rst  <= 1'b1;
            o_done     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_wb_cyc   <= cyc_nxt;
            o_wb_we    <= we_nxt;
            o_wb_adr   <= adr_nxt;
            o_wb_dat   <= dat_nxt;
            o_wb_sel   <= sel_nxt;
            o_byte_rdy <= (state_nxt == ST_FILL);
            o_cpu_rst  <= (state_nxt != ST_DONE);
            o_done     <= (state_nxt == ST_DONE);
            err_q      <= err_nxt;
            last_q     <= last_nxt;
        end
    end

endmodule

// File: tb/tb_servant_wb_loader.sv
// tb/tb_servant_wb_loader.sv - self-checking bench for servant_wb_loader (depth 16, autostart)
module tb_servant_wb_loader;

    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_d = 8'h00;
    logic        vld = 1'b0;
    logic        last = 1'b0;
    logic        rdy;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        cpu_rst, done, err;

    always #5 clk = ~clk;

    servant_wb_loader #(.depth(DEPTH), .AUTOSTART(1'b1)) dut (
        .i_wb_clk    (clk),
        .i_wb_rst    (rst),
        .i_start     (start),
        .i_byte      (byte_d),
        .i_byte_vld  (vld),
        .i_byte_last (last),
        .o_byte_rdy  (rdy),
        .o_wb_adr    (adr),
        .o_wb_dat    (dat),
        .o_wb_sel    (sel),
        .o_wb_we     (we),
        .o_wb_cyc    (cyc),
        .i_wb_rdt    (rdt),
        .i_wb_ack    (ack),
        .o_cpu_rst   (cpu_rst),
        .o_done      (done),
        .o_err       (err)
    );

    typedef struct {
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  img[$];
    int          img_last;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    int          cyc_cycles = 0;
    logic [1:0]  last_adr;
    logic [31:0] last_dat;
    logic [3:0]  last_sel;
    logic [31:0] mem [0:3];
    bit          corrupt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RAM slave: ack one cycle after cyc, single access per cycle; optional lane-2 corruption on read
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
            rdt <= 32'h0;
        end else begin
            ack <= cyc & ~ack;
            if (cyc && !ack && !we) rdt <= mem[adr] ^ (corrupt ? 32'h00ff_0000 : 32'h0);
            if (cyc && ack && we) begin
                for (int l = 0; l < 4; l++) begin
                    if (sel[l]) mem[adr][8*l +: 8] <= dat[8*l +: 8];
                end
            end
        end
    end

    // Per-cycle checks against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("cpu_rst_vs_done", cpu_rst, !done);
            chk("rdy_during_cyc", rdy & cyc, 1'b0);
`ifndef SERVANT_LOADER_VERIFY_EN
            chk("err_tied_low", err, 1'b0);
`endif
            if (cyc) cyc_cycles++;
            if (cyc && we && ack) begin
                wr_count++;
                last_adr = adr;
                last_dat = dat;
                last_sel = sel;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_adr", adr, e.adr);
                    chk("wr_dat", dat, e.dat);
                    chk("wr_sel", sel, e.sel);
                end
            end
        end
    end

    // Model: image ends at last byte or at RAM capacity; words packed little-endian from address 0
    task automatic model_image(output int n_eff);
        n_eff = (img_last >= 0) ? img_last + 1 : img.size();
        if (n_eff > CAP) n_eff = CAP;
        for (int w = 0; w * 4 < n_eff; w++) begin
            wr_t e;
            e.adr = w[1:0];
            e.dat = 32'h0;
            e.sel = 4'h0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < n_eff) begin
                    e.dat[8*l +: 8] = img[w*4+l];
                    e.sel[l] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, output bit ok);
        int n = 0;
        byte_d = b;
        last = l;
        vld = 1'b1;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = rdy;
        if (ok) @(negedge clk);
        vld = 1'b0;
        last = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, output int acc);
        bit ok;
        acc = 0;
        for (int i = from; i < to; i++) begin
            send_byte(img[i], i == img_last, ok);
            if (!ok) break;
            acc++;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_image(input string name);
        wait_done();
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_cpu_rst"}, cpu_rst, 1'b0);
        chk({name, "_rdy_low"}, rdy, 1'b0);
        chk({name, "_all_written"}, exp_q.size(), 0);
    endtask

    task automatic run_image(input string name);
        int n_eff, acc;
        model_image(n_eff);
        send_range(0, img.size(), acc);
        chk({name, "_accepted"}, acc, n_eff);
        finish_image(name);
    endtask

    initial begin
        int acc, wc, cc;
        bit ok;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", cyc, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_adr", adr, 2'd0);
        chk("rst_dat", dat, 32'h0);
        chk("rst_sel", sel, 4'h0);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("autostart_rdy", rdy, 1'b1);

        img = '{8'h13, 8'h04, 8'h80, 8'h00};
        img_last = 3;
        run_image("one_word");
        chk("one_word_adr", last_adr, 2'd0);
        chk("one_word_dat", last_dat, 32'h0080_0413);
        chk("one_word_sel", last_sel, 4'hf);

        pulse_start();
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        img_last = 6;
        run_image("seven");
        chk("seven_adr", last_adr, 2'd1);
        chk("seven_dat", last_dat, 32'h0007_0605);
        chk("seven_sel", last_sel, 4'h7);
        chk("seven_wr_total", wr_count, 3);

        pulse_start();
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'h10 + i));
        img_last = -1;
        run_image("capacity");
        chk("capacity_adr", last_adr, 2'd3);
        chk("capacity_dat", last_dat, 32'h1f1e_1d1c);
        chk("capacity_wr_total", wr_count, 7);

        pulse_start();
        img = '{8'hde, 8'had, 8'hbe, 8'hef};
        img_last = -1;
        send_range(0, 4, acc);
        chk("rst_test_accepted", acc, 4);
        cc = 0;
        while (!cyc && cc < 10) begin
            @(negedge clk);
            cc++;
        end
        chk("rst_test_cyc_seen", cyc, 1'b1);
        wc = wr_count;
        rst = 1'b1;
        #1;
        chk("async_rst_cyc", cyc, 1'b0);
        chk("async_rst_we", we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cc = cyc_cycles;
        repeat (8) @(negedge clk);
        chk("post_rst_no_cyc", cyc_cycles, cc);
        chk("post_rst_no_write", wr_count, wc);
        chk("post_rst_adr", adr, 2'd0);
        chk("post_rst_rdy", rdy, 1'b1);
        chk("post_rst_done", done, 1'b0);

        img = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5};
        img_last = 5;
        model_image(wc);
        send_range(0, 2, acc);
        pulse_start();
        chk("start_in_fill_adr", adr, 2'd0);
        chk("start_in_fill_rdy", rdy, 1'b1);
        send_range(2, 6, cc);
        chk("start_in_fill_accepted", acc + cc, wc);
        finish_image("start_in_fill");
        chk("start_in_fill_dat", last_dat, 32'h0000_a5a4);

`ifdef SERVANT_LOADER_VERIFY_EN
        pulse_start();
        corrupt = 1'b1;
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        img_last = 3;
        run_image("verify_bad");
        chk("verify_err_set", err, 1'b1);
        pulse_start();
        chk("verify_err_cleared", err, 1'b0);
        corrupt = 1'b0;
        run_image("verify_good");
        chk("verify_err_clean", err, 1'b0);
`endif

        send_byte(8'h55, 1'b1, ok);
        chk("done_rejects_bytes", ok, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
